// File: rtl/gpi_pkg.sv
// gpi_pkg: shared constants for the general-purpose input slot core.
//   Register word indices within the slot (also mirrored in software
//   headers) and the slot data-bus width.
package gpi_pkg;

  localparam int GPI_DW = 32;

  localparam logic [4:0] GPI_DATA = 5'd0;  // RO   debounced level
  localparam logic [4:0] GPI_EDGE = 5'd1;  // W1C  captured events
  localparam logic [4:0] GPI_MASK = 5'd2;  // RW   interrupt enable
  localparam logic [4:0] GPI_RISE = 5'd3;  // RW   rising-edge capture enable
  localparam logic [4:0] GPI_FALL = 5'd4;  // RW   falling-edge capture enable
  localparam logic [4:0] GPI_RAW  = 5'd5;  // RO   synchronised, undebounced level

endpackage

// File: rtl/gpi_debounce.sv
// gpi_debounce: one input bit of the GPI slot core.
//   A SYNC_STAGES flop chain brings the asynchronous input into the clk
//   domain; a counter then requires max(DB_CYCLES,1) consecutive cycles of
//   mismatch between the synchronised level and the held level before the
//   held level follows.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset (clears chain, counter, db)
//   din    asynchronous external input
//   raw    synchronised level (last flop of the chain)
//   db     debounced level
module gpi_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic raw,
  output logic db
);

  // 0 and 1 both collapse to a single acceptance cycle.
  localparam int DB_N = (DB_CYCLES < 2) ? 1 : DB_CYCLES;
  localparam int CW   = (DB_N > 1) ? $clog2(DB_N) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_N - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign raw = sync_q[SYNC_STAGES-1];

  // Any cycle where raw agrees with db restarts the count, so a glitch
  // shorter than DB_N cycles never reaches db.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      db    <= 1'b0;
    end else if (raw == db) begin
      cnt_q <= '0;
    end else if (cnt_q == DB_LAST) begin
      cnt_q <= '0;
      db    <= raw;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/gpi_irq.sv
// gpi_irq: general-purpose input slot core with per-bit synchronisation,
//   debouncing, programmable rise/fall event capture and a maskable,
//   registered level interrupt.
// Slot protocol: a write happens on the clk edge where cs & write is high;
//   rd_data is a pure combinational function of addr, so reads (read
//   strobe) have no side effects and need no handshake.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   cs, read, write slot chip select and strobes
//   addr            register word index (see gpi_pkg)
//   wr_data         write data, bits [31:W] ignored
//   rd_data         read data, bits [31:W] always 0
//   data_in         asynchronous external inputs
//   irq             |(EDGE & MASK), registered
module gpi_irq
  import gpi_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              read,
  input  logic              write,
  input  logic [4:0]        addr,
  input  logic [GPI_DW-1:0] wr_data,
  output logic [GPI_DW-1:0] rd_data,
  input  logic [W-1:0]      data_in,
  output logic              irq
);

  logic [W-1:0] raw;
  logic [W-1:0] db;
  logic [W-1:0] db_q;
  logic [W-1:0] edge_q;
  logic [W-1:0] mask_q;
  logic [W-1:0] rise_en_q;
  logic [W-1:0] fall_en_q;
  logic [W-1:0] edge_set;
  logic [W-1:0] edge_clr;
  logic [W-1:0] wdata;
  logic         wen;

  // read strobe and upper write-data bits carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{read, wr_data};

  for (genvar i = 0; i < W; i++) begin : g_bit
    gpi_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .din  (data_in[i]),
      .raw  (raw[i]),
      .db   (db[i])
    );
  end

  assign wen   = cs & write;
  assign wdata = wr_data[W-1:0];

  // Edge detection on the debounced level; db_q starts at 0 so an input
  // held high through reset shows up as a rise after release.
  assign edge_set = (db & ~db_q & rise_en_q) | (~db & db_q & fall_en_q);
  assign edge_clr = (wen && addr == GPI_EDGE) ? wdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q      <= '0;
      edge_q    <= '0;
      mask_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq       <= 1'b0;
    end else begin
      db_q   <= db;
      // Set is OR'd after the clear so a coincident event is not lost.
      edge_q <= (edge_q & ~edge_clr) | edge_set;
      irq    <= |(edge_q & mask_q);
      if (wen && addr == GPI_MASK) mask_q    <= wdata;
      if (wen && addr == GPI_RISE) rise_en_q <= wdata;
      if (wen && addr == GPI_FALL) fall_en_q <= wdata;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      GPI_DATA: rd_data[W-1:0] = db;
      GPI_EDGE: rd_data[W-1:0] = edge_q;
      GPI_MASK: rd_data[W-1:0] = mask_q;
      GPI_RISE: rd_data[W-1:0] = rise_en_q;
      GPI_FALL: rd_data[W-1:0] = fall_en_q;
      GPI_RAW:  rd_data[W-1:0] = raw;
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_gpi_irq.sv
// tb_gpi_irq: directed bench for gpi_irq with W=8, SYNC_STAGES=2,
//   DB_CYCLES=16 (L = 18 edges from input change to DATA).
module tb_gpi_irq;
  import gpi_pkg::*;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int DB = 16;
  localparam int L  = SS + DB;

  logic         clk = 1'b0;
  logic         reset;
  logic         cs;
  logic         read;
  logic         write;
  logic [4:0]   addr;
  logic [31:0]  wr_data;
  logic [31:0]  rd_data;
  logic [W-1:0] data_in;
  logic         irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  gpi_irq #(.W(W), .SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
    .clk    (clk),
    .reset  (reset),
    .cs     (cs),
    .read   (read),
    .write  (write),
    .addr   (addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .data_in(data_in),
    .irq    (irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance n rising edges, then settle 1ns past the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    step(1);
    cs = 1'b0; write = 1'b0; wr_data = '0;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a; read = 1'b1;
    #1;
    check(tag, rd_data, exp);
    read = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0; data_in = 8'hFF;
    step(3);

    // reset state, input already high
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd_check("rst_data", GPI_DATA, 32'h0);
    rd_check("rst_raw",  GPI_RAW,  32'h0);
    step(1);
    rd_check("rst_edge", GPI_EDGE, 32'h0);
    step(1);

    // held-high input after release appears as a rise
    reset = 1'b0;
    wr(GPI_RISE, 32'hFF);
    wr(GPI_MASK, 32'h01);
    step(15);                              // 17 edges
    rd_check("t1_data_L-1", GPI_DATA, 32'h00);
    rd_check("t1_raw",      GPI_RAW,  32'hFF);
    step(1);                               // L
    rd_check("t1_data_L",   GPI_DATA, 32'hFF);
    rd_check("t1_edge_L",   GPI_EDGE, 32'h00);
    check("t1_irq_L", {31'd0, irq}, 32'd0);
    step(1);                               // L+1
    rd_check("t1_edge_L+1", GPI_EDGE, 32'hFF);
    check("t1_irq_L+1", {31'd0, irq}, 32'd0);
    step(1);                               // L+2
    check("t1_irq_L+2", {31'd0, irq}, 32'd1);

    // clear all events, irq drops one cycle after the write edge
    wr(GPI_EDGE, 32'hFF);
    rd_check("clr_edge", GPI_EDGE, 32'h00);
    check("clr_irq_wr", {31'd0, irq}, 32'd1);
    step(1);
    check("clr_irq_next", {31'd0, irq}, 32'd0);

    // bit 3 low, then a 10-cycle glitch, then a held level
    data_in = 8'hF7;
    step(25);
    rd_check("p_data_low", GPI_DATA, 32'hF7);
    rd_check("p_edge_low", GPI_EDGE, 32'h00);
    data_in = 8'hFF;
    step(10);
    data_in = 8'hF7;
    step(30);
    rd_check("p_glitch_data", GPI_DATA, 32'hF7);
    rd_check("p_glitch_edge", GPI_EDGE, 32'h00);
    check("p_glitch_irq", {31'd0, irq}, 32'd0);
    data_in = 8'hFF;
    step(L - 1);
    rd_check("p_hold_L-1", GPI_DATA, 32'hF7);
    step(1);
    rd_check("p_hold_L",   GPI_DATA, 32'hFF);
    step(1);
    rd_check("p_hold_edge", GPI_EDGE, 32'h08);
    step(2);
    check("p_hold_irq_masked", {31'd0, irq}, 32'd0);

    // falling-edge capture on bit 2 only
    wr(GPI_RISE, 32'h00);
    wr(GPI_FALL, 32'h04);
    wr(GPI_EDGE, 32'hFF);
    wr(GPI_MASK, 32'h04);
    rd_check("f_edge_init", GPI_EDGE, 32'h00);
    data_in = 8'hFB;
    step(L + 1);
    rd_check("f_edge_fall", GPI_EDGE, 32'h04);
    check("f_irq_L+1", {31'd0, irq}, 32'd0);
    step(1);
    check("f_irq_L+2", {31'd0, irq}, 32'd1);
    wr(GPI_EDGE, 32'h04);
    rd_check("f_edge_w1c", GPI_EDGE, 32'h00);
    step(1);
    check("f_irq_drop", {31'd0, irq}, 32'd0);
    data_in = 8'hFF;
    step(25);
    rd_check("f_edge_rise_ign", GPI_EDGE, 32'h00);
    check("f_irq_rise_ign", {31'd0, irq}, 32'd0);

    // W1C coinciding with a new rise on bit 0: set wins
    wr(GPI_RISE, 32'h01);
    wr(GPI_FALL, 32'h01);
    wr(GPI_MASK, 32'h01);
    wr(GPI_EDGE, 32'hFF);
    data_in = 8'hFE;
    step(25);
    rd_check("c_edge_fall", GPI_EDGE, 32'h01);
    check("c_irq_fall", {31'd0, irq}, 32'd1);
    data_in = 8'hFF;
    step(L);
    wr(GPI_EDGE, 32'h01);                  // edge L+1: capture and clear together
    rd_check("c_edge_coll", GPI_EDGE, 32'h01);
    check("c_irq_coll", {31'd0, irq}, 32'd1);
    step(1);
    check("c_irq_coll_next", {31'd0, irq}, 32'd1);
    wr(GPI_EDGE, 32'h01);
    rd_check("c_edge_clr", GPI_EDGE, 32'h00);
    step(1);
    check("c_irq_clr", {31'd0, irq}, 32'd0);

    // unmapped indices and upper read bits
    rd_check("u_rd7", 5'd7, 32'h0);
    wr(5'd9, 32'hFFFF_FFFF);
    rd_check("u_mask", GPI_MASK, 32'h01);
    rd_check("u_rise", GPI_RISE, 32'h01);
    step(1);
    rd_check("u_fall", GPI_FALL, 32'h01);
    rd_check("u_edge", GPI_EDGE, 32'h00);
    rd_check("u_rd31", 5'd31, 32'h0);
    step(1);
    rd_check("u_data_upper", GPI_DATA, 32'h0000_00FF);

    // reset mid-debounce with an event pending
    wr(GPI_RISE, 32'h10);
    wr(GPI_FALL, 32'h00);
    wr(GPI_MASK, 32'hFF);
    data_in = 8'hEF;
    step(25);
    rd_check("r_edge_fall_ign", GPI_EDGE, 32'h00);
    data_in = 8'hFF;
    step(20);
    rd_check("r_edge_pend", GPI_EDGE, 32'h10);
    check("r_irq_pend", {31'd0, irq}, 32'd1);
    data_in = 8'hFE;
    step(5);
    reset = 1'b1;
    #1;
    check("r_irq_async", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 32; a++) exp_q.push_back(32'h0);
    for (int a = 0; a < 32; a++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      rd_check($sformatf("r_rd%0d", a), 5'(a), e);
      step(1);
    end
    reset = 1'b0;
    data_in = 8'hFF;
    wr(GPI_RISE, 32'hFF);
    step(L - 2);
    rd_check("r2_data_L-1", GPI_DATA, 32'h00);
    step(1);
    rd_check("r2_data_L", GPI_DATA, 32'hFF);
    step(1);
    rd_check("r2_edge", GPI_EDGE, 32'hFF);
    step(1);
    check("r2_irq_masked", {31'd0, irq}, 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpi_irq.md
# gpi_irq

Parametrised general-purpose input slot core with per-bit synchronisation, debouncing, programmable edge capture and a maskable level interrupt. It sits in an MMIO slot of the SoC bus fabric, uses the standard slot interface, and replaces the plain sampling input core for switches and buttons that need glitch filtering and event reporting to the processor.

## Interface

- W, 8, number of input bits (1..32)
- SYNC_STAGES, 2, synchroniser flops per bit (≥2)
- DB_CYCLES, 16, consecutive stable cycles before a level change is accepted; 0 or 1 means no filtering beyond one register stage

- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high reset
- cs  in  1  slot chip select
- read  in  1  read strobe (reads have no side effects)
- write  in  1  write strobe; a write occurs when cs & write
- addr  in  5  register index within the slot
- wr_data  in  32  write data
- rd_data  out  32  read data, combinational from addr; bits [31:W] always 0
- data_in  in  W  asynchronous external inputs
- irq  out  1  registered level interrupt to the interrupt controller

## Operation

- Register map (word index on addr): 0 DATA (RO) debounced level; 1 EDGE (R/W1C) captured events; 2 MASK (RW) interrupt enable; 3 RISE_EN (RW); 4 FALL_EN (RW); 5 RAW (RO) synchronised undebounced level. Indices 6..31: reads return 0, writes ignored.
- Only bits [W-1:0] of each register exist; wr_data[31:W] ignored.
- Per bit: SYNC_STAGES flop chain -> sync; debouncer holds db and a counter. sync == db: counter <= 0. sync != db: counter increments; when counter == max(DB_CYCLES,1)-1 and still mismatched, db <= sync, counter <= 0. A mismatch that disappears before acceptance resets the counter; db unchanged.
- db_q is db delayed one cycle. rise = db & ~db_q; fall = ~db & db_q.
- EDGE[i] sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]); stays set until cleared by writing 1 to that bit of EDGE. Writing 0 has no effect.
- irq <= |(EDGE & MASK), registered.
- Reset values: sync chain, db, db_q, counters, EDGE, MASK, RISE_EN, FALL_EN all 0; irq 0; rd_data reflects reset registers (DATA reads 0).

## Timing

- Let L = SYNC_STAGES + max(DB_CYCLES,1), counting rising edges from the first edge that samples the new data_in level (input held stable).
- RAW changes after SYNC_STAGES edges; DATA after L; EDGE bit after L+1; irq after L+2.
- Register writes take effect on the clk edge where cs & write is high; readback visible the following cycle.
- Simultaneous W1C of EDGE[i] and a new qualifying edge on bit i: set wins, bit stays 1.
- Clearing MASK or EDGE drops irq one cycle after the write edge.
- Changing RISE_EN/FALL_EN does not retroactively capture past edges.
- Reset asserted mid-debounce or with EDGE pending: everything returns to reset values immediately; after release a held-high input produces a rise (it appears as 0->1 from reset db).
- Input pulses shorter than DB_CYCLES cycles (after sync) never change DATA or EDGE when DB_CYCLES ≥ 2.

## Structure

- Package gpi_pkg: register index constants (GPI_DATA=0, GPI_EDGE=1, GPI_MASK=2, GPI_RISE=3, GPI_FALL=4, GPI_RAW=5) and the slot data width constant (32); shared with other slot cores and software headers.
- Sub-module gpi_debounce: one bit, contains synchroniser, counter and db register, parameters SYNC_STAGES and DB_CYCLES; generated W times in gpi_irq. Edge capture, registers, read mux and irq stay in gpi_irq.

## Test plan

- Reset with data_in=8'hFF, release, RISE_EN=8'hFF, MASK=8'h01 -> DATA=8'hFF after L cycles, EDGE=8'hFF, irq=1 two cycles after DATA changes.
- DB_CYCLES=16: bit 3 pulses high for 10 cycles -> DATA, EDGE unchanged, irq 0; held 20 cycles -> DATA[3]=1 exactly L cycles after assertion.
- FALL_EN=8'h04 only, bit 2 toggles 1->0 and 0->1 -> EDGE=8'h04 only on the fall; write EDGE=8'h04 -> EDGE=0, irq drops next cycle.
- W1C of EDGE[0] on the same cycle as a new rise on bit 0 -> EDGE[0] remains 1, irq stays 1.
- Read addr 7 and write addr 9 with wr_data=32'hFFFFFFFF -> read 0, no register changes; read DATA with W=8 -> rd_data[31:8]=0.
- Assert reset during debounce with EDGE=8'h10 and MASK=8'hFF -> irq, EDGE, MASK 0 immediately, rd_data=0 for all addresses.
